gpio_mul_sched: RTL and testbench

Round-robin scheduler that shares the bus-mapped 24×24 multiply/popcount engine among `N_REQ` requesters. It accepts one job at a time and drives the engine's register interface (`saddress`/`swr`/`srd` strobes). It writes operands, starts the engine, polls status, reads back product and ones-count, and returns them to the winning requester. It sits between the requester logic and the engine's slave bus.

---
 rtl/gpio_mul_sched.sv | 277 +++++++++++++++++++++++++++
 tb/tb_gpio_mul_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mul_sched.sv
// Round-robin front end that time-shares the bus-mapped 24x24 multiply/popcount engine.
// Each engine register access is a fixed SETUP/STROBE/HOLD triple driven from registered state.
module gpio_mul_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned POLL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*24-1:0]   req_a,
    input  logic [N_REQ*24-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [2:0]            rsp_id,
    output logic [31:0]           rsp_w,
    output logic [23:0]           rsp_l,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           saddress,
    output logic                  swr,
    output logic                  srd,
    output logic [31:0]           sdata_out,
    input  logic [31:0]           sdata_in
);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StArb  = 4'd1;
    localparam logic [3:0] StWrA1 = 4'd2;
    localparam logic [3:0] StWrA2 = 4'd3;
    localparam logic [3:0] StWrGo = 4'd4;
    localparam logic [3:0] StPoll = 4'd5;
    localparam logic [3:0] StRdW  = 4'd6;
    localparam logic [3:0] StRdL  = 4'd7;
    localparam logic [3:0] StResp = 4'd8;

    localparam logic [1:0] PhSetup  = 2'd0;
    localparam logic [1:0] PhStrobe = 2'd1;
    localparam logic [1:0] PhHold   = 2'd2;

    localparam logic [15:0] AddrA1   = 16'h0380;
    localparam logic [15:0] AddrA2   = 16'h0388;
    localparam logic [15:0] AddrW    = 16'h0390;
    localparam logic [15:0] AddrL    = 16'h0398;
    localparam logic [15:0] AddrCtrl = 16'h03A0;

    localparam logic [2:0] LastIdx = 3'(N_REQ - 1);
    localparam logic [3:0] NumReq  = 4'(N_REQ);
    localparam logic [7:0] PollLim = 8'(POLL_LIMIT);

    logic [3:0]  r_state;
    logic [1:0]  r_phase;
    logic [2:0]  r_rr_ptr;
    logic [7:0]  r_poll_cnt;
    logic [23:0] r_a;
    logic [23:0] r_b;
    logic [2:0]  r_id;
    logic [31:0] r_w;
    logic [23:0] r_l;
    logic        r_err;

    logic [3:0]  w_state_nxt;
    logic [1:0]  w_phase_nxt;
    logic [2:0]  w_rr_ptr_nxt;
    logic [7:0]  w_poll_cnt_nxt;
    logic [23:0] w_a_nxt;
    logic [23:0] w_b_nxt;
    logic [2:0]  w_id_nxt;
    logic [31:0] w_w_nxt;
    logic [23:0] w_l_nxt;
    logic        w_err_nxt;

    logic [7:0]  w_valid_pad;
    logic [23:0] w_a_arr [8];
    logic [23:0] w_b_arr [8];
    logic        w_found;
    logic [2:0]  w_grant;
    logic [3:0]  w_sum;
    logic [2:0]  w_cand;
    logic        w_bus_state;
    logic        w_bus_last;
    logic [7:0]  w_poll_inc;

    // Pad requester vectors to 8 entries so a 3-bit index always selects cleanly.
    always_comb begin
        w_valid_pad = '0;
        for (int i = 0; i < 8; i++) begin
            w_a_arr[i] = '0;
            w_b_arr[i] = '0;
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_valid_pad[i] = req_valid[i];
            w_a_arr[i]     = req_a[24*i +: 24];
            w_b_arr[i]     = req_b[24*i +: 24];
        end
    end

    // First valid requester at or after r_rr_ptr, scanning upward with wrap.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_sum = {1'b0, r_rr_ptr} + 4'(k);
            if (w_sum >= NumReq) begin
                w_sum = w_sum - NumReq;
            end
            w_cand = w_sum[2:0];
            if (!w_found && w_valid_pad[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_bus_state = (r_state == StWrA1) || (r_state == StWrA2) || (r_state == StWrGo) ||
                         (r_state == StPoll) || (r_state == StRdW)  || (r_state == StRdL);
    assign w_bus_last  = (r_phase == PhHold);
    assign w_poll_inc  = r_poll_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_poll_cnt_nxt = r_poll_cnt;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_id_nxt       = r_id;
        w_w_nxt        = r_w;
        w_l_nxt        = r_l;
        w_err_nxt      = r_err;

        if (w_bus_state) begin
            if (!w_bus_last) begin
                w_phase_nxt = r_phase + 2'd1;
            end else begin
                w_phase_nxt = PhSetup;
                case (r_state)
                    StWrA1: w_state_nxt = StWrA2;
                    StWrA2: w_state_nxt = StWrGo;
                    StWrGo: begin
                        w_poll_cnt_nxt = '0;
                        w_state_nxt    = StPoll;
                    end
                    StPoll: begin
                        w_poll_cnt_nxt = w_poll_inc;
                        if (sdata_in[1]) begin
                            w_state_nxt = StRdW;
                        end else if (w_poll_inc == PollLim) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = StResp;
                        end else begin
                            w_state_nxt = StPoll;
                        end
                    end
                    StRdW: begin
                        w_w_nxt     = sdata_in;
                        w_state_nxt = StRdL;
                    end
                    StRdL: begin
                        w_l_nxt     = sdata_in[23:0];
                        w_state_nxt = StResp;
                    end
                    default: w_state_nxt = StIdle;
                endcase
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (|req_valid) begin
                        w_state_nxt = StArb;
                    end
                end
                StArb: begin
                    // A request withdrawn before grant simply returns us to idle.
                    if (w_found) begin
                        w_rr_ptr_nxt   = (w_grant == LastIdx) ? 3'd0 : w_grant + 3'd1;
                        w_a_nxt        = w_a_arr[w_grant];
                        w_b_nxt        = w_b_arr[w_grant];
                        w_id_nxt       = w_grant;
                        w_w_nxt        = '0;
                        w_l_nxt        = '0;
                        w_err_nxt      = 1'b0;
                        w_poll_cnt_nxt = '0;
                        w_phase_nxt    = PhSetup;
                        w_state_nxt    = StWrA1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
                StResp: w_state_nxt = (|req_valid) ? StArb : StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state    <= StIdle;
            r_phase    <= PhSetup;
            r_rr_ptr   <= '0;
            r_poll_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= '0;
            r_w        <= '0;
            r_l        <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_poll_cnt <= w_poll_cnt_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_id       <= w_id_nxt;
            r_w        <= w_w_nxt;
            r_l        <= w_l_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = (r_state == StArb) && w_found && (w_grant == 3'(i));
        end
    end

    always_comb begin
        rsp_valid = (r_state == StResp);
        rsp_id    = rsp_valid ? r_id  : 3'd0;
        rsp_w     = rsp_valid ? r_w   : 32'd0;
        rsp_l     = rsp_valid ? r_l   : 24'd0;
        rsp_err   = rsp_valid ? r_err : 1'b0;
        busy      = (r_state != StIdle) && (r_state != StArb);
    end

    // Address/data are held for the whole access; only the strobe is phase-gated.
    always_comb begin
        saddress  = '0;
        sdata_out = '0;
        swr       = 1'b0;
        srd       = 1'b0;
        case (r_state)
            StWrA1: begin
                saddress  = AddrA1;
                sdata_out = {8'd0, r_a};
                swr       = (r_phase == PhStrobe);
            end
            StWrA2: begin
                saddress  = AddrA2;
                sdata_out = {8'd0, r_b};
                swr       = (r_phase == PhStrobe);
            end
            StWrGo: begin
                saddress = AddrCtrl;
                swr      = (r_phase == PhStrobe);
            end
            StPoll: begin
                saddress = AddrCtrl;
                srd      = (r_phase == PhStrobe);
            end
            StRdW: begin
                saddress = AddrW;
                srd      = (r_phase == PhStrobe);
            end
            StRdL: begin
                saddress = AddrL;
                srd      = (r_phase == PhStrobe);
            end
            default: begin
                saddress = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_mul_sched.sv
// Directed bench for gpio_mul_sched with a behavioural multiply/popcount engine on the slave bus.
module tb_gpio_mul_sched;

    localparam int NR = 4;
    localparam int PL = 4;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*24-1:0] req_a = '0;
    logic [NR*24-1:0] req_b = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [2:0]      rsp_id;
    logic [31:0]     rsp_w;
    logic [23:0]     rsp_l;
    logic            rsp_err;
    logic            busy;
    logic [15:0]     saddress;
    logic            swr;
    logic            srd;
    logic [31:0]     sdata_out;
    logic [31:0]     sdata_in;

    int n_checks = 0;
    int n_pass   = 0;

    gpio_mul_sched #(
        .N_REQ      (NR),
        .POLL_LIMIT (PL)
    ) u_dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_w     (rsp_w),
        .rsp_l     (rsp_l),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .saddress  (saddress),
        .swr       (swr),
        .srd       (srd),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    always #5 clk = ~clk;

    // Engine model: start write clears its poll count; status bit1 rises on poll eng_done_at.
    logic [23:0] eng_a1 = '0;
    logic [23:0] eng_a2 = '0;
    int          eng_polls = 0;
    int          eng_done_at = 0;
    logic [47:0] eng_prod;
    logic [31:0] eng_w;

    always @(posedge clk) begin
        if (swr) begin
            case (saddress)
                16'h0380: eng_a1 <= sdata_out[23:0];
                16'h0388: eng_a2 <= sdata_out[23:0];
                16'h03A0: eng_polls <= 0;
                default: ;
            endcase
        end
        if (srd && saddress == 16'h03A0) eng_polls <= eng_polls + 1;
    end

    always_comb begin
        eng_prod = eng_a1 * eng_a2;
        eng_w    = eng_prod[31:0];
        sdata_in = '0;
        case (saddress)
            16'h0390: sdata_in = eng_w;
            16'h0398: sdata_in = 32'($countones(eng_w));
            16'h03A0: sdata_in = {30'd0, (eng_done_at != 0 && eng_polls >= eng_done_at), 1'b0};
            default:  sdata_in = '0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic do_reset();
        n_reset   = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  id;
        logic [23:0] a;
        logic [23:0] b;
        int          done;
        logic [31:0] w;
        logic [23:0] l;
        logic        err;
        int          lat;
        int          polls;
    } vec_t;

    vec_t vecs[6];

    task automatic run_job(input vec_t v, input bit chk_bus);
        bit          got;
        bit          seen;
        int          lat;
        int          ph;
        logic [15:0] ea;
        logic [31:0] ed;
        eng_done_at = v.done;
        req_a[v.id*24 +: 24] = v.a;
        req_b[v.id*24 +: 24] = v.b;
        req_valid = 4'b0001 << v.id;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (|req_ready) got = 1'b1;
        end
        check("grant", 128'(req_ready), 128'(4'b0001 << v.id));
        if (got) begin
            @(posedge clk);
            #1 req_valid = '0;
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 200) begin
                @(negedge clk);
                lat++;
                if (rsp_valid) seen = 1'b1;
                if (chk_bus && lat <= 9) begin
                    ph = (lat - 1) % 3;
                    ea = (lat <= 3) ? 16'h0380 : (lat <= 6) ? 16'h0388 : 16'h03A0;
                    ed = (lat <= 3) ? {8'd0, v.a} : (lat <= 6) ? {8'd0, v.b} : 32'd0;
                    check($sformatf("bus_c%0d", lat), {saddress, sdata_out, swr, srd},
                          {ea, ed, (ph == 1), 1'b0});
                end
            end
            check("rsp_latency", 128'(lat), 128'(v.lat));
            check("rsp_id",      128'(rsp_id), 128'(v.id));
            check("rsp_w",       128'(rsp_w), 128'(v.w));
            check("rsp_l",       128'(rsp_l), 128'(v.l));
            check("rsp_err",     128'(rsp_err), 128'(v.err));
            check("busy_resp",   128'(busy), 128'(1'b1));
            check("poll_count",  128'(eng_polls), 128'(v.polls));
        end
    endtask

    initial begin
        bit got;
        int cnt;
        int rsp_seen;

        vecs[0] = '{3'd2, 24'd3, 24'd5, 2, 32'd15, 24'd4, 1'b0, 22, 2};
        vecs[1] = '{3'd0, 24'hFFFFFF, 24'hFFFFFF, 1, 32'hFE000001, 24'd8, 1'b0, 19, 1};
        vecs[2] = '{3'd1, 24'h001000, 24'h000100, 3, 32'h00100000, 24'd1, 1'b0, 25, 3};
        vecs[3] = '{3'd3, 24'd7, 24'd9, 0, 32'd0, 24'd0, 1'b1, 22, 4};
        vecs[4] = '{3'd3, 24'h123456, 24'd0, 4, 32'd0, 24'd0, 1'b0, 28, 4};
        vecs[5] = '{3'd1, 24'h800000, 24'd2, 1, 32'h01000000, 24'd1, 1'b0, 19, 1};

        do_reset();
        check("reset_rsp", {req_ready, rsp_valid, rsp_id, rsp_w, rsp_l, rsp_err, busy}, '0);
        check("reset_bus", {saddress, swr, srd, sdata_out}, '0);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], (i == 0));
        end

        // Round robin: all requesters held valid, grants must rotate 0,1,2,3,0 back-to-back.
        do_reset();
        eng_done_at = 1;
        req_valid   = 4'hF;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            cnt = 0;
            while (!got && cnt < 60) begin
                @(negedge clk);
                cnt++;
                if (|req_ready) got = 1'b1;
            end
            check($sformatf("rr_grant%0d", g), 128'(req_ready), 128'(4'b0001 << (g % 4)));
            if (g > 0) check($sformatf("rr_gap%0d", g), 128'(cnt), 128'(20));
        end

        // Reset during RD_W: outputs clear at once, no response, pointer back to 0.
        do_reset();
        eng_done_at = 1;
        req_a[2*24 +: 24] = 24'd3;
        req_b[2*24 +: 24] = 24'd5;
        req_valid = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (|req_ready) got = 1'b1;
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (13) @(negedge clk);
        check("mid_rdw_addr", 128'(saddress), 128'(16'h0390));
        n_reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp", {req_ready, rsp_valid, rsp_id, rsp_w, rsp_l, rsp_err, busy}, '0);
        check("mid_rst_bus", {saddress, swr, srd, sdata_out}, '0);
        @(negedge clk);
        n_reset  = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("mid_rst_no_rsp", 128'(rsp_seen), 128'(0));
        req_valid = 4'b1001;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (|req_ready) got = 1'b1;
        end
        check("post_rst_grant", 128'(req_ready), 128'(4'b0001));
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
